// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces the
// full 16-key vector over consecutive identical scans, turns each clean
// single-key press into an ASCII character and hands it to a UART
// transmitter through a start/busy handshake. A one-entry pending register
// decouples key presses from the transmitter; presses arriving while it is
// occupied are dropped and flagged on key_overflow.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  input  logic       TxD_busy,
  output logic       TxD_start,
  output logic [7:0] TxD_data,
  output logic       key_overflow
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  // Row synchronizer
  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;

  // Column scan
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      raw_q, raw_d;
  logic             slot_end;
  logic             scan_end;

  // Debounce and press detection
  logic [15:0]      prev_q, prev_d;
  logic [15:0]      deb_q, deb_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic             press_ev;
  logic [3:0]       key_idx;
  logic [7:0]       key_char;

  // Pending buffer and transmit handshake
  state_t           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       tmo_q, tmo_d;
  logic             ovf_q, ovf_d;

  // Row-major key map: "123A" / "456B" / "789C" / "*0#D".
  function automatic logic [7:0] key_ascii(input logic [3:0] idx);
    logic [7:0] ch;
    case (idx)
      4'd0:    ch = 8'h31;
      4'd1:    ch = 8'h32;
      4'd2:    ch = 8'h33;
      4'd3:    ch = 8'h41;
      4'd4:    ch = 8'h34;
      4'd5:    ch = 8'h35;
      4'd6:    ch = 8'h36;
      4'd7:    ch = 8'h42;
      4'd8:    ch = 8'h37;
      4'd9:    ch = 8'h38;
      4'd10:   ch = 8'h39;
      4'd11:   ch = 8'h43;
      4'd12:   ch = 8'h2A;
      4'd13:   ch = 8'h30;
      4'd14:   ch = 8'h23;
      default: ch = 8'h44;
    endcase
    return ch;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs; idles at "no key".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Column timing: sample the active column at the end of its slot, then rotate.
  always_comb begin
    slot_end = (div_q == DIV_LAST);
    scan_end = slot_end && (col_q == 2'd3);
    div_d    = slot_end ? '0 : div_q + DIV_W'(1);
    col_d    = slot_end ? col_q + 2'd1 : col_q;
    raw_d    = raw_q;
    if (slot_end) begin
      raw_d[{2'd0, col_q}] = ~row_sync_q[0];
      raw_d[{2'd1, col_q}] = ~row_sync_q[1];
      raw_d[{2'd2, col_q}] = ~row_sync_q[2];
      raw_d[{2'd3, col_q}] = ~row_sync_q[3];
    end
    col_n = ~(4'b0001 << col_q);
  end

  // Scan counter, active column and raw key vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      col_q <= '0;
      raw_q <= '0;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      raw_q <= raw_d;
    end
  end

  // Debounce on full-scan boundaries. The comparison uses the vector that
  // includes column 3's fresh sample, so a scan is judged in the cycle it ends.
  always_comb begin
    prev_d   = prev_q;
    deb_d    = deb_q;
    stable_d = stable_q;
    press_ev = 1'b0;
    if (scan_end) begin
      if (raw_d == prev_q) begin
        stable_d = (stable_q == CNT_MAX) ? stable_q : stable_q + CNT_W'(1);
      end else begin
        stable_d = '0;
      end
      prev_d = raw_d;
      if (stable_d == CNT_MAX) begin
        deb_d = raw_d;
        // Only an idle-to-single-key transition counts as a press.
        press_ev = (deb_q == '0) && $onehot(raw_d);
      end
    end
  end

  // Encode the pressed key index from the single set bit.
  always_comb begin
    key_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (raw_d[i]) begin
        key_idx = 4'(i);
      end
    end
    key_char = key_ascii(key_idx);
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      deb_q    <= '0;
      stable_q <= '0;
    end else begin
      prev_q   <= prev_d;
      deb_q    <= deb_d;
      stable_q <= stable_d;
    end
  end

  // Transmit handshake FSM with the pending register. The unload in IDLE is
  // applied before the press load, so a same-cycle press refills the slot.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    start_d      = 1'b0;
    data_d       = data_q;
    tmo_d        = tmo_q;
    ovf_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q && !TxD_busy) begin
          data_d       = pend_data_q;
          start_d      = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A transmitter that never raises busy is treated as already done.
        if (TxD_busy) begin
          state_d = S_WAIT_LO;
        end else if (tmo_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      S_WAIT_LO: begin
        if (!TxD_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (press_ev) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_data_d  = key_char;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Transmit FSM, pending register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      start_q      <= 1'b0;
      data_q       <= '0;
      tmo_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      start_q      <= start_d;
      data_q       <= data_d;
      tmo_q        <= tmo_d;
      ovf_q        <= ovf_d;
    end
  end

  assign TxD_start    = start_q;
  assign TxD_data     = data_q;
  assign key_overflow = ovf_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces it, and converts each clean single-key press into one 8-bit ASCII character.
- Presents each character to the UART transmitter using the async_transmitter start/busy handshake.
- Sits directly upstream of async_transmitter and replaces the fixed-string test generator in the room terminal.

Parameters:
- SCAN_DIV, 50000: clk cycles each column is driven (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_SCANS, 20: consecutive identical full scans required before the debounced key vector updates; minimum 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous reset, active-low.
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_n  output  4  keypad column drive, active-low, exactly one column low at a time.
- TxD_busy  input  1  high while async_transmitter is sending.
- TxD_start  output  1  one-cycle request to transmit TxD_data.
- TxD_data  output  8  ASCII character to send.
- key_overflow  output  1  one-cycle pulse when a press is dropped.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0:
  - col_n=4'b1110, TxD_start=0, TxD_data=8'h00, key_overflow=0.
  - All counters, the synchronizer, vectors and the pending register clear; the FSM is in IDLE.
  - Reset mid-transfer abandons the character with no further TxD_start.
- Row synchronizer: row_n passes through a 2-flop synchronizer before use.
- Scan:
  - div counts 0..SCAN_DIV-1 per column.
  - At div=SCAN_DIV-1, the inverted synchronized rows are stored into raw[r*4+c] for the active column c, and col_n rotates 1110->1101->1011->0111->1110.
  - A full scan completes when column 3's slot ends.
- Debounce, evaluated at each full-scan end:
  - raw==prev_raw: stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: stable_cnt=0.
  - prev_raw<=raw in both cases.
  - When stable_cnt reaches DEBOUNCE_SCANS, deb<=raw.
- Press detect:
  - A press event fires when deb transitions from 16'h0000 to a vector with exactly one bit set.
  - Multi-key vectors and releases produce nothing.
  - No new event is possible until deb returns to 0, so a held key sends exactly one character.
- Key map, index 0..15 (row-major: row 0 = "123A", row 1 = "456B", row 2 = "789C", row 3 = "*0#D"):
  - 0x31 0x32 0x33 0x41
  - 0x34 0x35 0x36 0x42
  - 0x37 0x38 0x39 0x43
  - 0x2A 0x30 0x23 0x44
- Pending buffer:
  - One-entry holding register pend_data/pend_valid.
  - A press event with pend_valid=0 loads it.
  - A press event with pend_valid=1 drops the new press and pulses key_overflow for 1 cycle.
- TX FSM:
  - IDLE: if pend_valid and TxD_busy=0, then TxD_data<=pend_data, TxD_start<=1, pend_valid<=0, go to START.
  - START: TxD_start<=0, timeout counter=0, go to WAIT_HI.
  - WAIT_HI: TxD_busy=1 goes to WAIT_LO. If busy is not seen within 4 cycles, go to IDLE (assumes a 1-cycle transfer).
  - WAIT_LO: TxD_busy=0 goes to IDLE.
  - TxD_start is high for exactly one cycle per character.
  - TxD_data holds its value until the next load.
- Simultaneous press event and IDLE unload in the same cycle: the unload happens first and the new press loads pend, with no overflow.
- Latency from a stable press to TxD_start: at most (DEBOUNCE_SCANS+2) full scans + 3 cycles.

Test Plan (sim parameters SCAN_DIV=8, DEBOUNCE_SCANS=3; TxD_busy model goes high 1 cycle after TxD_start and stays high 20 cycles):
- Reset release -> col_n=1110, TxD_start=0, TxD_data=00. col_n rotates every 8 cycles: 1110, 1101, 1011, 0111, 1110.
- Hold key row1/col2 ('6') for 10 scans, then release -> exactly one TxD_start pulse with TxD_data=8'h36, one cycle wide, and no further pulses while the key is held.
- Key '0' (row3/col1) bounces for 2 scans, then holds stable -> exactly one TxD_data=8'h30. No character is sent during the bounce.
- Press '1' and '#' together, release, then press 'D' -> no character for the combo, then one TxD_data=8'h44.
- Force TxD_busy=1 continuously; press '5' then 'A' then '9' -> '5' waits in pend, 'A' pulses key_overflow, '9' pulses key_overflow. After busy drops, one TxD_data=8'h35.
- Assert reset_n=0 in WAIT_LO with pend_valid=1 -> outputs return to reset values immediately, and no TxD_start follows release of reset.
